// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - md_defs: MDControl encodings, state type and default cycle counts
package md_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

    function automatic logic is_launch_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle mult/div unit owning HI/LO, busy for a fixed cycle count
module mult_div_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDControl,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_op_e op;
    assign op = md_op_e'(MDControl);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        div_zero;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u   = {32'd0, A} * {32'd0, B};
        a_neg    = A[31];
        b_neg    = B[31];
        mag_a    = a_neg ? (~A + 32'd1) : A;
        mag_b    = b_neg ? (~B + 32'd1) : B;
        div_zero = (B == 32'd0);
        sq_mag   = div_zero ? 32'd0 : (mag_a / mag_b);
        sr_mag   = div_zero ? 32'd0 : (mag_a % mag_b);
        uq       = div_zero ? 32'd0 : (A / B);
        ur       = div_zero ? 32'd0 : (A % B);
    end

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_wr = 1'b1;
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_wr = 1'b1;
            end
            MD_DIV: begin
                res_lo = (a_neg ^ b_neg) ? (~sq_mag + 32'd1) : sq_mag;
                res_hi = a_neg ? (~sr_mag + 32'd1) : sr_mag;
                res_wr = !div_zero;
            end
            MD_DIVU: begin
                res_lo = uq;
                res_hi = ur;
                res_wr = !div_zero;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
                res_wr = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start && is_launch_op(op)) begin
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    pend_wr_d = res_wr;
                    cnt_d     = is_mult_op(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_d   = ST_RUN;
                end else if (op == MD_MTHI) begin
                    hi_d = A;
                end else if (op == MD_MTLO) begin
                    lo_d = A;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign Busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against a behavioural model
module tb_mult_div_unit;
    import md_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDControl;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_err = 0;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .MDControl (MDControl),
        .Start     (Start),
        .Busy      (Busy),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining busy cycles plus the result to commit.
    int          m_left = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    logic [31:0] m_phi = 0;
    logic [31:0] m_plo = 0;
    logic        m_wr = 0;
    bit          model_en = 0;

    always @(posedge clk) begin
        longint      sa, sb, q, r;
        logic [63:0] p;
        int          ai, bi;
        if (reset) begin
            m_left = 0;
            m_hi   = 0;
            m_lo   = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_wr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (Start && MDControl >= 3'd1 && MDControl <= 3'd4) begin
            ai = A;
            bi = B;
            m_wr = 1'b1;
            case (MDControl)
                3'd1: begin sa = ai; sb = bi; p = 64'(sa * sb); end
                3'd2: p = {32'd0, A} * {32'd0, B};
                3'd3: begin
                    sa = ai; sb = bi;
                    if (sb == 0) m_wr = 1'b0;
                    else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
                end
                default: begin
                    if (B == 0) m_wr = 1'b0;
                    else p = {A % B, A / B};
                end
            endcase
            m_phi  = p[63:32];
            m_plo  = p[31:0];
            m_left = (MDControl <= 3'd2) ? 5 : 10;
        end else if (MDControl == 3'd5) begin
            m_hi = A;
        end else if (MDControl == 3'd6) begin
            m_lo = A;
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            check("model_busy", {31'd0, Busy}, {31'd0, (m_left > 0)});
            check("model_hi", HI, m_hi);
            check("model_lo", LO, m_lo);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_cyc, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input string nm);
        int n;
        step();
        MDControl = op; A = a; B = b; Start = 1'b1;
        step();
        MDControl = 3'd0; Start = 1'b0;
        n = 0;
        while (Busy && n < 40) begin
            n++;
            step();
        end
        check({nm, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
        check({nm, "_hi"}, HI, exp_hi);
        check({nm, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        int n;
        logic [31:0] specials [4];
        specials[0] = 32'h0; specials[1] = 32'h1;
        specials[2] = 32'hFFFFFFFF; specials[3] = 32'h80000000;

        reset = 1'b1; A = 0; B = 0; MDControl = 0; Start = 0;
        step();
        step();
        reset = 1'b0;
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_hi", HI, 32'h0);
        check("reset_lo", LO, 32'h0);
        model_en = 1;

        do_op(3'd1, 32'hFFFFFFFF, 32'h2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
        do_op(3'd2, 32'hFFFFFFFF, 32'h2, 5, 32'h00000001, 32'hFFFFFFFE, "multu");
        do_op(3'd3, 32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
        do_op(3'd4, 32'h7, 32'h2, 10, 32'h1, 32'h3, "divu");
        do_op(3'd4, 32'h7, 32'h0, 10, 32'h1, 32'h3, "divu_zero");
        do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, "div_ovf");

        step();
        MDControl = 3'd5; A = 32'h12345678;
        step();
        MDControl = 3'd0;
        check("mthi_hi", HI, 32'h12345678);

        // mtlo and a second Start inside RUN must be ignored
        step();
        MDControl = 3'd1; A = 32'd3; B = 32'd4; Start = 1'b1;
        step();
        MDControl = 3'd6; A = 32'hDEADBEEF; Start = 1'b0;
        step();
        MDControl = 3'd3; A = 32'd100; B = 32'd7; Start = 1'b1;
        step();
        MDControl = 3'd0; Start = 1'b0;
        n = 2;
        while (Busy && n < 40) begin
            n++;
            step();
        end
        check("run_ignore_cycles", 32'(n), 32'd5);
        check("run_ignore_hi", HI, 32'h0);
        check("run_ignore_lo", LO, 32'd12);

        // reset in busy cycle 3 discards the pending divide
        step();
        MDControl = 3'd4; A = 32'd7; B = 32'd2; Start = 1'b1;
        step();
        MDControl = 3'd0; Start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_run_busy", {31'd0, Busy}, 32'd0);
        check("rst_run_hi", HI, 32'h0);
        check("rst_run_lo", LO, 32'h0);
        repeat (12) step();
        check("rst_nocommit_hi", HI, 32'h0);
        check("rst_nocommit_lo", LO, 32'h0);

        for (int i = 0; i < 1500; i++) begin
            step();
            reset     = ($urandom_range(0, 299) == 0);
            MDControl = 3'($urandom_range(0, 7));
            Start     = ($urandom_range(0, 2) == 0);
            A = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            B = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 4) == 0) B = 32'($urandom_range(0, 9));
        end
        step();
        reset = 1'b0; Start = 1'b0; MDControl = 3'd0;
        repeat (12) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit for the P6 pipelined MIPS core. It sits in the E stage beside the single-cycle ALU. It accepts `mult`/`multu`/`div`/`divu` operands with a one-cycle start pulse and owns the architectural HI/LO registers. It exposes a `Busy` flag that the hazard unit uses to stall HI/LO-dependent instructions in D.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration of `mult`/`multu`, in cycles. Must be ≥1.
- `DIV_CYCLES`, default 10: busy duration of `div`/`divu`, in cycles. Must be ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `A`  in  32  rs operand (forwarded value)
- `B`  in  32  rt operand (forwarded value)
- `MDControl`  in  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- `Start`  in  1  one-cycle pulse qualifying ops 1–4
- `Busy`  out  1  high while an operation is in flight
- `HI`  out  32  architectural HI register (registered output)
- `LO`  out  32  architectural LO register (registered output)

## Operation
- Reset values: `Busy`=0, `HI`=0, `LO`=0, internal counter=0, pending result=0.
- States: IDLE (`Busy`=0) and RUN (`Busy`=1). A 4-bit down-counter `cnt` holds the remaining cycles.
- Launch rule:
  - In IDLE, when `Start`=1 and `MDControl`∈{1..4`}`, the edge captures the result into pending HI/LO registers, loads `cnt` with `MULT_CYCLES` or `DIV_CYCLES`, and enters RUN.
  - `Start` with any other `MDControl` is ignored.
- Arithmetic:
  - `mult`: signed 32×32→64. `multu`: unsigned 32×32→64. In both, {HI,LO} = product.
  - `div`: signed. LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - `divu`: unsigned quotient and remainder.
  - `div` with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No exception is raised.
  - Divide by zero (B=0, `div` or `divu`): the full busy duration still elapses, and HI/LO are left unchanged at commit.
- RUN: every edge decrements `cnt`. On the edge where `cnt`==1, HI/LO are written from the pending registers and the unit returns to IDLE.
- `mthi`/`mtlo`:
  - In IDLE, they write A into HI or LO at the next edge. `Start` is not required.
  - In RUN, they are ignored.
- In RUN, `Start` is ignored and the in-flight operation is neither restarted nor cancelled.
- `HI`/`LO` outputs change only at commit, at an mthi/mtlo write, or at reset.
- The unit raises no overflow signal and no exception output.

## Timing
- Cycle 0: `Start` is high, with operands valid. At the end of cycle 0 the edge launches the operation.
- Cycles 1..N (N = MULT_CYCLES or DIV_CYCLES): `Busy`=1 for exactly N cycles.
- The edge ending cycle N commits the result. In cycle N+1, `Busy`=0 and the new HI/LO are visible in the same cycle.
- Back-to-back: a new `Start` in cycle N+1 launches normally. `Start` in cycle N is ignored.
- Stall contract: the hazard unit stalls D-stage mult/div/mfhi/mflo/mthi/mtlo while `Start`|`Busy` is high.
- mthi/mtlo latency: 1 edge. HI/LO are readable in the following cycle.
- Reset asserted mid-RUN: at the next edge `Busy`=0 and HI=LO=0. The pending result is discarded. Reset has priority over commit on the same edge.

## Structure
- Shared package/header (`md_defs`): `MDControl` encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO) and the default cycle counts. The decoder in the controller also uses these.
- Keep the module flat, with no sub-module. It contains:
  - combinational product/quotient computation into pending registers
  - the counter
  - the IDLE/RUN state bit
  - the HI/LO registers

## Test plan
- mult, A=0xFFFFFFFF, B=0x00000002, Start pulse → `Busy` high for 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div, A=0xFFFFFFF9 (−7), B=2 → 10 busy cycles. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, A=7, B=2 → LO=3, HI=1.
- divu, A=7, B=0 → HI/LO keep their prior values and `Busy` still lasts 10 cycles.
- div, A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi A=0x12345678 in IDLE → HI=0x12345678 the next cycle.
- During RUN, apply mtlo and a second Start → both are ignored, and the original result commits on schedule.
- Start div, assert reset in busy cycle 3 → the next cycle shows `Busy`=0 and HI=LO=0. No commit follows.
